note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//  Plays a stored sequence of (tone, duration) entries. Drives the 10-bit tone code into the
//  tone LUT and a gate to the oscillator/envelope. Lets the player be scripted instead of held on
//  switches. Sits between the control/UI logic and the tone LUT + phase accumulator.
// PARAMETERS
//  DEPTH          16        number of sequence entries (power of 2, >=2); AW = $clog2(DEPTH)
//  DUR_WIDTH      8         width of per-entry duration, in units
//  TICKS_PER_UNIT 1_000_000 clk cycles per duration unit (>=1)
//  GAP_TICKS      100_000   gate-low cycles inserted after each note (0 allowed)
// PORTS
//  clk_in       in   1          system clock
//  rst_in       in   1          asynchronous, active-high reset
//  wr_en_in     in   1          write one sequence entry this cycle
//  wr_addr_in   in   AW         entry index to write
//  wr_tone_in   in   10         tone code (0 = rest)
//  wr_dur_in    in   DUR_WIDTH  duration in units (0 = skip entry)
//  len_in       in   AW+1       number of entries to play, sampled on start
//  loop_in      in   1          1: wrap to entry 0 after last; sampled on start
//  start_in     in   1          begin playback (ignored unless idle)
//  stop_in      in   1          abort playback
//  tone_out     out  10         tone code to tone LUT
//  gate_out     out  1          1 while a non-rest note sounds
//  busy_out     out  1          1 in any state except IDLE
//  idx_out      out  AW         entry currently fetched/playing
//  done_out     out  1          1-cycle pulse on natural end of a non-looping sequence
// BEHAVIOUR
//  - Reset (async): state IDLE; tone_out=0, gate_out=0, busy_out=0, idx_out=0, done_out=0.
//    Entry memory contents not reset (undefined until written).
//  - Memory: DEPTH x (10+DUR_WIDTH), 1 write port, synchronous read. Read-first on same-address
//    write. Writes are accepted in every state. A write to the playing entry does not change the
//    current note; it applies on the next fetch of that entry.
//  - FSM: IDLE -> FETCH -> PLAY -> GAP -> FETCH ... -> IDLE.
//  - IDLE: tone_out=0, gate_out=0. On start_in & !stop_in: latch len = min(len_in, DEPTH) and
//    loop_in; idx=0. len==0 -> done_out pulses next cycle, stay IDLE. Otherwise -> FETCH.
//  - FETCH (1 cycle): read entry[idx]; gate_out=0. dur==0 -> advance (see below) without PLAY.
//  - PLAY: tone_out=entry tone. gate_out = (tone!=0). Lasts exactly dur*TICKS_PER_UNIT cycles.
//    Use a prescaler counter (0..TICKS_PER_UNIT-1) plus a unit counter; no wide multiply.
//  - GAP: gate_out=0, tone_out held, GAP_TICKS cycles; skipped when GAP_TICKS==0.
//  - Advance: idx==len-1 -> loop ? idx=0, FETCH : done_out=1, IDLE. Else idx+1, FETCH.
//  - Latency: start sampled at edge 0 -> FETCH at cycle 1 -> gate_out high from cycle 2.
//    Gate-low between two notes = GAP_TICKS + 1 cycles (GAP + FETCH).
//  - stop_in: any state -> IDLE on next edge. tone_out=0, gate_out=0, no done pulse.
//    stop beats start in the same cycle. start_in while busy is ignored.
//  - A sequence of all skip entries (dur 0) with loop=1 cycles through FETCH states forever,
//    gate low. This is legal; stop_in exits.
//  - All outputs registered; done_out exactly 1 cycle wide.
// TESTING (DEPTH=4, DUR_WIDTH=4, TICKS_PER_UNIT=4, GAP_TICKS=2)
//  1 entries {220,2},{440,1}, len=2, loop=0, start -> gate high 8 cyc tone 220 from cycle 2.
//    Then gate low 3 cyc, then gate high 4 cyc tone 440, low 2 (GAP). Then done_out pulse, IDLE.
//  2 same sequence with loop=1 -> after 440 note, low 3 cyc, 220 replays. stop_in mid-note ->
//    next cycle gate_out=0, tone_out=0, busy_out=0, done_out never asserted.
//  3 entries {375,1},{0,2},{750,0},{750,1}, len=4 -> 375 gate 4 cyc. Then rest: gate low for
//    3 + 8 + 3 cyc. Entry 2 is skipped (FETCH only), so the next FETCH adds 1 cyc low.
//    Then 750 gate high 4 cyc.
//  4 len_in=0 start -> done_out pulse at cycle 1, busy_out never high. len_in=7 -> plays 4 entries.
//  5 corner events: start+stop same cycle -> stays IDLE. start while busy -> no restart.
//    Rewrite playing entry's tone mid-PLAY -> current tone unchanged, new tone on next loop.
//  6 async reset asserted mid-PLAY between clock edges -> outputs 0 immediately. Release, start
//    -> normal playback from entry 0 with memory contents preserved.

Source files
------------

// File: rtl/note_sequencer.sv
// Plays a stored list of (tone, duration) entries as a gated tone stream.
// Each entry goes through FETCH -> PLAY -> GAP. A duration of 0 skips the entry; a tone of 0 is a rest.
module note_sequencer #(
    parameter  int DEPTH          = 16,
    parameter  int DUR_WIDTH      = 8,
    parameter  int TICKS_PER_UNIT = 1_000_000,
    parameter  int GAP_TICKS      = 100_000,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 wr_en_in,
    input  logic [AW-1:0]        wr_addr_in,
    input  logic [9:0]           wr_tone_in,
    input  logic [DUR_WIDTH-1:0] wr_dur_in,
    input  logic [AW:0]          len_in,
    input  logic                 loop_in,
    input  logic                 start_in,
    input  logic                 stop_in,
    output logic [9:0]           tone_out,
    output logic                 gate_out,
    output logic                 busy_out,
    output logic [AW-1:0]        idx_out,
    output logic                 done_out
);

    localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int GAP_LAST_I = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_UNIT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_LAST_I);
    localparam logic [AW:0]   DEPTH_LEN  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [AW:0]            len_q, len_d;
    logic                   loop_q, loop_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [DUR_WIDTH-1:0]   unit_q, unit_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [9:0]             tone_d;
    logic                   gate_d, done_d, busy_d, adv;

    logic [9+DUR_WIDTH:0]   mem [DEPTH];
    logic [9+DUR_WIDTH:0]   rd_q;
    logic [9:0]             rd_tone;
    logic [DUR_WIDTH-1:0]   rd_dur;

    assign rd_tone = rd_q[DUR_WIDTH +: 10];
    assign rd_dur  = rd_q[DUR_WIDTH-1:0];
    assign idx_out = idx_q;

    // NOTE: the entry RAM has no reset so it maps onto block/distributed RAM; contents survive rst_in.
    // The read address is the next index, so the entry is ready during FETCH; same-edge writes are read-first.
    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem[wr_addr_in] <= {wr_tone_in, wr_dur_in};
        end
        rd_q <= mem[idx_d];
    end

    // NOTE: every signal gets a default before the case statement so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        loop_d  = loop_q;
        presc_d = presc_q;
        unit_d  = unit_q;
        gap_d   = gap_q;
        tone_d  = tone_out;
        gate_d  = 1'b0;
        done_d  = 1'b0;
        adv     = 1'b0;

        case (state_q)
            IDLE: begin
                tone_d = '0;
                if (start_in) begin
                    len_d  = (len_in > DEPTH_LEN) ? DEPTH_LEN : len_in;
                    loop_d = loop_in;
                    idx_d  = '0;
                    if (len_in == '0) done_d  = 1'b1;
                    else              state_d = FETCH;
                end
            end
            FETCH: begin
                if (rd_dur == '0) begin
                    adv = 1'b1;
                end else begin
                    state_d = PLAY;
                    tone_d  = rd_tone;
                    gate_d  = (rd_tone != '0);
                    presc_d = '0;
                    unit_d  = rd_dur - DUR_WIDTH'(1);
                end
            end
            PLAY: begin
                gate_d = (tone_out != '0);
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (unit_q == '0) begin
                        gate_d = 1'b0;
                        if (GAP_TICKS == 0) begin
                            adv = 1'b1;
                        end else begin
                            state_d = GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        unit_d = unit_q - DUR_WIDTH'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) adv   = 1'b1;
                else                   gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if ({1'b0, idx_q} == len_q - (AW+1)'(1)) begin
                idx_d = '0;
                if (loop_q) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    tone_d  = '0;
                end
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = FETCH;
            end
        end

        // Abort wins over everything, including a start or a natural end in the same cycle.
        if (stop_in) begin
            state_d = IDLE;
            idx_d   = '0;
            tone_d  = '0;
            gate_d  = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            presc_q  <= '0;
            unit_q   <= '0;
            gap_q    <= '0;
            tone_out <= '0;
            gate_out <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            presc_q  <= presc_d;
            unit_q   <= unit_d;
            gap_q    <= gap_d;
            tone_out <= tone_d;
            gate_out <= gate_d;
            busy_out <= busy_d;
            done_out <= done_d;
        end
    end

endmodule
